// File: rtl/mono_readout_if.sv
// Chip-side and FIFO-side signals of the MONOPIX readout sequencer.
// The controller uses the master modport; the chip/FIFO side uses the slave modport.
interface mono_readout_if;
    logic        TOKEN;
    logic        DATA;
    logic        FIFO_FULL;
    logic        FREEZE;
    logic        READ;
    logic        CLK_OUT_EN;
    logic        FIFO_WRITE;
    logic [31:0] FIFO_DATA;

    modport master (
        input  TOKEN, DATA, FIFO_FULL,
        output FREEZE, READ, CLK_OUT_EN, FIFO_WRITE, FIFO_DATA
    );

    modport slave (
        output TOKEN, DATA, FIFO_FULL,
        input  FREEZE, READ, CLK_OUT_EN, FIFO_WRITE, FIFO_DATA
    );
endinterface

// File: rtl/mono_readout_ctrl.sv
// MONOPIX readout sequencer: freezes the matrix on TOKEN, pulses READ, shifts one
// serial hit word per pulse and pushes it to the readout FIFO.
module mono_readout_ctrl #(
    parameter int unsigned DATA_BITS  = 26,
    parameter logic [3:0]  IDENTIFIER = 4'b0001
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CONF_EN,
    input  logic [7:0]           CONF_FREEZE_SETUP,
    input  logic [7:0]           CONF_READ_WIDTH,
    input  logic [7:0]           CONF_READ_DELAY,
    input  logic [7:0]           CONF_FREEZE_HOLD,
    mono_readout_if.master       bus,
    output logic                 BUSY,
    output logic [7:0]           LOST_CNT
);
    localparam int unsigned CNT_W     = 8;
    localparam int unsigned HDR_W     = 4;
    localparam int unsigned PAYLOAD_W = 32 - HDR_W;
    localparam logic [CNT_W-1:0] SHIFT_LOAD = CNT_W'(DATA_BITS - 1);

    generate
        if (DATA_BITS < 1 || DATA_BITS > 28) begin : g_bad_data_bits
            $error("mono_readout_ctrl: DATA_BITS must be in 1..28");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE, SETUP, READ_P, WAIT, SHIFT, PUSH, NEXT, HOLD
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic                 tok_meta, tok_s;
    logic [DATA_BITS-1:0] shreg;
    logic                 freeze, read, clk_out_en, fifo_write, busy;
    logic [31:0]          fifo_data;
    logic [7:0]           lost_cnt;

    // Counter value for a state lasting max(1, cycles) cycles; the counter ends at zero.
    function automatic logic [CNT_W-1:0] span(input logic [CNT_W-1:0] cycles);
        return (cycles == '0) ? '0 : cycles - CNT_W'(1);
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Zero READ delay and zero hold skip their states entirely.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = (cnt == '0) ? '0 : cnt - CNT_W'(1);
        case (state)
            IDLE: begin
                if (CONF_EN && tok_s) begin
                    state_nxt = SETUP;
                    cnt_nxt   = span(CONF_FREEZE_SETUP);
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_nxt = READ_P;
                    cnt_nxt   = span(CONF_READ_WIDTH);
                end
            end
            READ_P: begin
                if (cnt == '0) begin
                    if (CONF_READ_DELAY == '0) begin
                        state_nxt = SHIFT;
                        cnt_nxt   = SHIFT_LOAD;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = span(CONF_READ_DELAY);
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt = SHIFT;
                    cnt_nxt   = SHIFT_LOAD;
                end
            end
            SHIFT: begin
                if (cnt == '0) state_nxt = PUSH;
            end
            PUSH: state_nxt = NEXT;
            NEXT: begin
                if (tok_s && CONF_EN) begin
                    state_nxt = READ_P;
                    cnt_nxt   = span(CONF_READ_WIDTH);
                end else if (CONF_FREEZE_HOLD == '0) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = HOLD;
                    cnt_nxt   = span(CONF_FREEZE_HOLD);
                end
            end
            HOLD: begin
                if (cnt == '0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Token sync, shift register and registered chip/FIFO outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tok_meta   <= 1'b0;
            tok_s      <= 1'b0;
            shreg      <= '0;
            freeze     <= 1'b0;
            read       <= 1'b0;
            clk_out_en <= 1'b0;
            fifo_write <= 1'b0;
            fifo_data  <= '0;
            busy       <= 1'b0;
            lost_cnt   <= '0;
        end else begin
            tok_meta   <= bus.TOKEN;
            tok_s      <= tok_meta;
            freeze     <= (state != IDLE);
            read       <= (state == READ_P);
            clk_out_en <= (state == SHIFT);
            busy       <= (state_nxt != IDLE);
            fifo_write <= (state == PUSH) && !bus.FIFO_FULL;
            if (state == SHIFT) shreg <= DATA_BITS'({shreg, bus.DATA});
            if (state == PUSH) begin
                if (!bus.FIFO_FULL) fifo_data <= {IDENTIFIER, PAYLOAD_W'(shreg)};
                else if (lost_cnt != '1) lost_cnt <= lost_cnt + 8'd1;
            end
        end
    end

    assign bus.FREEZE     = freeze;
    assign bus.READ       = read;
    assign bus.CLK_OUT_EN = clk_out_en;
    assign bus.FIFO_WRITE = fifo_write;
    assign bus.FIFO_DATA  = fifo_data;
    assign BUSY           = busy;
    assign LOST_CNT       = lost_cnt;
endmodule

// File: doc/mono_readout_ctrl.md
Name: mono_readout_ctrl

Overview:
- Readout sequencer between the FPGA data path and the MONOPIX matrix readout interface.
- On TOKEN it freezes the matrix and issues READ pulses. For each pulse it gates the serial output clock and shifts in one DATA_BITS-wide hit word, then pushes the word into the readout FIFO.
- It releases FREEZE once TOKEN drops.
- Sits beside the data receiver in the MIO firmware, driving FREEZE, READ and the Clk_Out enable.

Parameters:
DATA_BITS, 26, serial hit-word length shifted per READ
IDENTIFIER, 4'b0001, stream tag placed in FIFO_DATA[31:28]

Ports:
CLK  input  1  readout clock; all logic on rising edge
RST  input  1  synchronous, active-high reset
CONF_EN  input  1  enables new readout cycles
CONF_FREEZE_SETUP  input  8  cycles FREEZE is high before first READ
CONF_READ_WIDTH  input  8  READ pulse length in cycles; 0 treated as 1
CONF_READ_DELAY  input  8  cycles between READ falling and shift start
CONF_FREEZE_HOLD  input  8  cycles FREEZE stays high after last word
TOKEN  input  1  chip token, asynchronous
DATA  input  1  chip serial data, sampled on CLK
FIFO_FULL  input  1  downstream FIFO full
FREEZE  output  1  to chip FREEZE
READ  output  1  to chip READ
CLK_OUT_EN  output  1  gate for chip Clk_Out
FIFO_WRITE  output  1  one-cycle write strobe
FIFO_DATA  output  32  {IDENTIFIER, zero pad, hit word}
BUSY  output  1  high whenever state != IDLE
LOST_CNT  output  8  words dropped on FIFO_FULL, saturating

Behaviour:
- Reset: all outputs 0, state IDLE, shift register 0, LOST_CNT 0, token synchronizer cleared. RST mid-operation aborts immediately; FREEZE/READ drop at the next edge.
- TOKEN passes through a 2-FF synchronizer (tok_s). DATA is sampled directly.
- IDLE: CONF_EN && tok_s go to SETUP. FREEZE goes high at the third edge after TOKEN is first sampled high.
- SETUP: FREEZE=1 for CONF_FREEZE_SETUP cycles (0 means go to READ next edge), then READ_P.
- READ_P: READ=1 for max(1,CONF_READ_WIDTH) cycles, then WAIT.
- WAIT: CONF_READ_DELAY cycles (0 allowed), then SHIFT.
- SHIFT: CLK_OUT_EN=1 for exactly DATA_BITS cycles. Each cycle does shreg <= {shreg[DATA_BITS-2:0], DATA}, so the first bit ends up as the MSB. Then PUSH.
- PUSH (1 cycle):
  - FIFO_FULL=0: FIFO_WRITE=1 and FIFO_DATA = {IDENTIFIER, zeros, shreg[DATA_BITS-1:0]}.
  - FIFO_FULL=1: no write; LOST_CNT increments, saturating at 255.
  - FIFO_DATA holds its last value outside PUSH.
- NEXT (1 cycle):
  - tok_s && CONF_EN: READ_P, with FREEZE kept high and no SETUP repeated.
  - Otherwise: HOLD.
- HOLD: FREEZE=1 for CONF_FREEZE_HOLD cycles, then FREEZE=0 and IDLE. A further TOKEN is honoured only from IDLE, with full SETUP.
- CONF_EN deasserted mid-word: the current word completes and is pushed, then HOLD. TOKEN dropping mid-word is ignored until NEXT.
- FREEZE is high in every state except IDLE. READ is high only in READ_P. CLK_OUT_EN is high only in SHIFT. All three are registered outputs.
- Config inputs are sampled on counter load (state entry). Changes mid-state take effect at the next load.
- Cycles per word after the first: max(1,W) + D + DATA_BITS + 2.
- DATA_BITS must be in 1..28; larger values are an elaboration error.

Test Plan:
1. S=2,W=1,D=0,HOLD=1, TOKEN rises at edge 0, DATA pattern 26'h2AAAAAA, TOKEN drops during SHIFT.
   - Expect FREEZE at edge 3, READ high edges 5–6, CLK_OUT_EN high 26 cycles, one FIFO_WRITE.
   - Expect FIFO_DATA=32'h12AAAAAA, then FREEZE low 1 cycle after HOLD, BUSY 0.
2. TOKEN held high for 3 words with distinct DATA patterns -> three FIFO_WRITEs in order, FREEZE never deasserted between words, spacing 29 cycles with W=1,D=0.
3. FIFO_FULL=1 for 300 words -> zero FIFO_WRITEs, LOST_CNT saturates at 8'hFF; FIFO_FULL=0 next word -> write occurs, LOST_CNT stays 255.
4. CONF_READ_WIDTH=0, CONF_FREEZE_SETUP=0 -> READ exactly 1 cycle, READ rises the edge after FREEZE rises.
5. RST asserted mid-SHIFT -> next edge: FREEZE, READ, CLK_OUT_EN, FIFO_WRITE, BUSY, LOST_CNT all 0; no partial word written after RST drops.
6. CONF_EN dropped in WAIT with TOKEN high -> current word pushed, then HOLD and IDLE; no new READ while CONF_EN=0.
